// File: rtl/uart_pkg.sv
// Shared UART definitions for the CPU-facing receive and transmit paths.
//
// Contents:
//   - CPU byte addresses of the transmit register, receive data port and
//     receive status port
//   - bit positions inside the receive status word
//   - receiver state encoding used by uart_rx_phy
//   - even-parity helper used when UART_RX_PARITY_EN is defined
package uart_pkg;

    localparam logic [31:0] UART_TX_ADDR        = 32'h0000_7EEF;
    localparam logic [31:0] UART_RX_DATA_ADDR   = 32'h0000_7EF0;
    localparam logic [31:0] UART_RX_STATUS_ADDR = 32'h0000_7EF4;

    localparam int STAT_NOT_EMPTY  = 0;
    localparam int STAT_FULL       = 1;
    localparam int STAT_FRAME_ERR  = 2;
    localparam int STAT_OVERRUN    = 3;
    localparam int STAT_PARITY_ERR = 4;
    localparam int STAT_IDX_LSB    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // True when the data byte plus its parity bit hold an even number of ones.
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/uart_rx_phy.sv
// Serial front end of the UART receiver.
//
// Synchronizes the asynchronous rx line, detects the start bit, and samples
// each bit at its centre using a baud counter. Emits 1-cycle pulses on the
// stop-sample cycle.
//
// Configuration macro: UART_RX_PARITY_EN (adds an even-parity bit, 8E1 frame).
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   rx          in   serial input, idle high
//   byte_valid  out  pulse: byte_data holds a correctly framed byte
//   byte_data   out  received byte (LSB received first)
//   frame_err   out  pulse: stop bit sampled low
//   parity_err  out  pulse: parity mismatch with a good stop bit
module uart_rx_phy
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_sample;
    logic          parity_bad;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    // All reset high so that reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Edge-triggered start detection keeps a low line after a bad stop bit
    // from being taken as a fresh start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_sync;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // Leave on the sample itself so the next start edge,
                    // half a bit later, is already watched for.
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_bad = ~even_parity_ok(shreg, par_bit);
`else
    assign parity_bad = 1'b0;
`endif

    assign stop_sample = (state == ST_STOP) && (cnt == BIT_LAST);
    assign byte_data   = shreg;
    assign byte_valid  = stop_sample && rx_sync && !parity_bad;
    assign frame_err   = stop_sample && !rx_sync;
    assign parity_err  = stop_sample && rx_sync && parity_bad;

endmodule

// File: rtl/uart_rx_top.sv
// Memory-mapped UART receive path.
//
// Packs four received bytes into a 32-bit word (first byte in [31:24]),
// queues words in a FIFO, and serves CPU reads of the data and status ports.
//
// Configuration macro: UART_RX_PARITY_EN (8E1 frames, status bit4 live).
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   rx       in   serial input, idle high
//   re       in   CPU read strobe
//   address  in   CPU byte address
//   dataOut  out  registered read data, valid the edge after re
//   rx_irq   out  high while the FIFO holds at least one word
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    input  logic        re,
    input  logic [31:0] address,
    output logic [31:0] dataOut,
    output logic        rx_irq
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  frame_err;
    logic                  parity_err;

    logic [1:0]            byte_idx;
    logic [23:0]           word_hi;
    logic [31:0]           push_word;
    logic                  push_pending;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  not_empty;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  status_rd;

    logic                  framing_flag;
    logic                  overrun_flag;
    logic                  parity_flag;
    logic [31:0]           status;

    uart_rx_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_phy (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    assign not_empty = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign pop       = re && (address == UART_RX_DATA_ADDR) && not_empty;
    assign status_rd = re && (address == UART_RX_STATUS_ADDR);
    // A full FIFO still accepts the word when a pop frees the slot this edge.
    assign push_ok   = push_pending && (!full || pop);
    assign rx_irq    = not_empty;

    // Word assembly. A bad frame resets the index so the partial word is
    // lost; stale bytes in word_hi are shifted out before they are reused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx     <= '0;
            word_hi      <= '0;
            push_word    <= '0;
            push_pending <= 1'b0;
        end else begin
            push_pending <= 1'b0;
            if (frame_err || parity_err) begin
                byte_idx <= '0;
            end else if (byte_valid) begin
                if (byte_idx == 2'd3) begin
                    push_word    <= {word_hi, byte_data};
                    push_pending <= 1'b1;
                    byte_idx     <= '0;
                end else begin
                    word_hi  <= {word_hi[15:0], byte_data};
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. A status read clears them, but a new event in the
    // same cycle keeps its flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            framing_flag <= 1'b0;
            overrun_flag <= 1'b0;
            parity_flag  <= 1'b0;
        end else begin
            framing_flag <= frame_err | (framing_flag & ~status_rd);
            overrun_flag <= (push_pending && full && !pop) | (overrun_flag & ~status_rd);
            parity_flag  <= parity_err | (parity_flag & ~status_rd);
        end
    end

    always_comb begin
        status                                = '0;
        status[STAT_NOT_EMPTY]                = not_empty;
        status[STAT_FULL]                     = full;
        status[STAT_FRAME_ERR]                = framing_flag;
        status[STAT_OVERRUN]                  = overrun_flag;
`ifdef UART_RX_PARITY_EN
        status[STAT_PARITY_ERR]               = parity_flag;
`endif
        status[STAT_IDX_LSB +: 2]             = byte_idx;
    end

    // Registered read port; holds its last value between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataOut <= '0;
        end else if (re) begin
            if (address == UART_RX_DATA_ADDR) begin
                dataOut <= not_empty ? mem[rd_ptr] : '0;
            end else if (address == UART_RX_STATUS_ADDR) begin
                dataOut <= status;
            end else begin
                dataOut <= '0;
            end
        end
    end

endmodule
